// File: rtl/hazard_pkg.sv
// Shared types and geometry for the hazard grid encoder.
// Optional occupancy counter is enabled with HAZARD_OCC_COUNT_EN.
package hazard_pkg;

  localparam int N_SLOTS   = 16;
  localparam int COORD_W   = 11;
  localparam int GRID_ROWS = 4;
  localparam int GRID_COLS = 8;
  localparam int CELL_W    = 160;
  localparam int CELL_H    = 180;
  localparam int N_CELLS   = GRID_ROWS * GRID_COLS;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t top;
    coord_t left;
    coord_t bottom;
    coord_t right;
  } box_t;

  function automatic logic [5:0] popcount32(input logic [N_CELLS-1:0] v);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < N_CELLS; i++) begin
      cnt = cnt + 6'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/hazard_box_cells.sv
// Combinational cell mask for one hazard box: bit r*8+c set when the box
// overlaps cell (r,c). Cell edges are compile-time 12-bit constants.
module hazard_box_cells
  import hazard_pkg::*;
(
  input  box_t               box_i,
  input  logic               active_i,
  output logic [N_CELLS-1:0] mask_o
);

  logic box_valid;
  logic [11:0] top_x, left_x, bottom_x, right_x;

  assign top_x    = {1'b0, box_i.top};
  assign left_x   = {1'b0, box_i.left};
  assign bottom_x = {1'b0, box_i.bottom};
  assign right_x  = {1'b0, box_i.right};

  // Degenerate boxes never mark anything.
  assign box_valid = active_i && (left_x <= right_x) && (top_x <= bottom_x);

  genvar gi;
  generate
    for (gi = 0; gi < N_CELLS; gi++) begin : g_cell
      localparam logic [11:0] X_LO = 12'(CELL_W * (gi % GRID_COLS));
      localparam logic [11:0] X_HI = 12'(CELL_W * (gi % GRID_COLS) + CELL_W - 1);
      localparam logic [11:0] Y_LO = 12'(CELL_H * (gi / GRID_COLS));
      localparam logic [11:0] Y_HI = 12'(CELL_H * (gi / GRID_COLS) + CELL_H - 1);

      assign mask_o[gi] = box_valid
                          && (left_x <= X_HI) && (right_x >= X_LO)
                          && (top_x <= Y_HI) && (bottom_x >= Y_LO);
    end
  endgenerate

endmodule

// File: rtl/hazard_grid_encoder.sv
// Encodes up to 15 hazard boxes into a registered 4x8 occupancy map.
// Define HAZARD_OCC_COUNT_EN to add the registered occ_count output.
module hazard_grid_encoder
  import hazard_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         num_hazards,
  input  logic [COORD_W-1:0] top    [N_SLOTS],
  input  logic [COORD_W-1:0] left   [N_SLOTS],
  input  logic [COORD_W-1:0] bottom [N_SLOTS],
  input  logic [COORD_W-1:0] right  [N_SLOTS],
  output logic [15:0]        vec1,
  output logic [15:0]        vec2
`ifdef HAZARD_OCC_COUNT_EN
  ,
  output logic [5:0]         occ_count
`endif
);

  logic [N_CELLS-1:0] slot_mask [N_SLOTS];
  logic [N_CELLS-1:0] map_d, map_q;

  genvar gi;
  generate
    for (gi = 0; gi < N_SLOTS; gi++) begin : g_slot
      box_t slot_box;
      logic slot_active;

      assign slot_box    = '{top: top[gi], left: left[gi], bottom: bottom[gi], right: right[gi]};
      assign slot_active = (4'(gi) < num_hazards);

      hazard_box_cells u_cells (
        .box_i    (slot_box),
        .active_i (slot_active),
        .mask_o   (slot_mask[gi])
      );
    end
  endgenerate

  always_comb begin
    map_d = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      map_d = map_d | slot_mask[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      map_q <= '0;
    end else begin
      map_q <= map_d;
    end
  end

  assign vec1 = map_q[15:0];
  assign vec2 = map_q[31:16];

`ifdef HAZARD_OCC_COUNT_EN
  logic [5:0] occ_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_count_q <= '0;
    end else begin
      occ_count_q <= popcount32(map_d);
    end
  end

  assign occ_count = occ_count_q;
`endif

endmodule

// File: tb/tb_hazard_grid_encoder.sv
// Self-checking bench for hazard_grid_encoder: directed cases plus random
// boxes checked against an interval-overlap reference model.
module tb_hazard_grid_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  num_hazards;
  logic [10:0] top    [16];
  logic [10:0] left   [16];
  logic [10:0] bottom [16];
  logic [10:0] right  [16];
  logic [15:0] vec1, vec2;
`ifdef HAZARD_OCC_COUNT_EN
  logic [5:0]  occ_count;
`endif

  int total_cnt = 0;
  int pass_cnt  = 0;
  logic [31:0] exp_map;

  hazard_grid_encoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .num_hazards (num_hazards),
    .top         (top),
    .left        (left),
    .bottom      (bottom),
    .right       (right),
    .vec1        (vec1),
    .vec2        (vec2)
`ifdef HAZARD_OCC_COUNT_EN
    ,
    .occ_count   (occ_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference: a cell is hit when the box's x and y intervals intersect the cell's.
  function automatic logic [31:0] model_map();
    logic [31:0] m;
    int xl, xh, yl, yh;
    m = '0;
    for (int i = 0; i < int'(num_hazards); i++) begin
      if (left[i] > right[i] || top[i] > bottom[i]) continue;
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 8; c++) begin
          xl = (int'(left[i])   > 160*c)       ? int'(left[i])   : 160*c;
          xh = (int'(right[i])  < 160*c + 159) ? int'(right[i])  : 160*c + 159;
          yl = (int'(top[i])    > 180*r)       ? int'(top[i])    : 180*r;
          yh = (int'(bottom[i]) < 180*r + 179) ? int'(bottom[i]) : 180*r + 179;
          if (xl <= xh && yl <= yh) m[r*8 + c] = 1'b1;
        end
      end
    end
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] m);
    check({tag, ".vec1"}, 32'(vec1), 32'(m[15:0]));
    check({tag, ".vec2"}, 32'(vec2), 32'(m[31:16]));
`ifdef HAZARD_OCC_COUNT_EN
    check({tag, ".occ"}, 32'(occ_count), 32'($countones(m)));
`endif
    $display("%s: nh=%0d vec1=%h vec2=%h", tag, num_hazards, vec1, vec2);
  endtask

  task automatic set_box(input int i, input int t, input int l, input int b, input int r);
    top[i] = 11'(t); left[i] = 11'(l); bottom[i] = 11'(b); right[i] = 11'(r);
  endtask

  task automatic randomize_boxes();
    for (int i = 0; i < 16; i++) begin
      set_box(i, $urandom_range(0, 800), $urandom_range(0, 1400),
                 $urandom_range(0, 800), $urandom_range(0, 1400));
    end
  endtask

  // Drive, clock once, then sample 1 time unit after the edge.
  task automatic step(input string tag, input logic [31:0] m);
    @(posedge clk);
    #1;
    check_outputs(tag, m);
  endtask

  initial begin
    rst_n = 1'b0;
    num_hazards = 4'd15;
    randomize_boxes();
    step("reset0", 32'h0);
    randomize_boxes();
    step("reset1", 32'h0);
    rst_n = 1'b1;

    randomize_boxes();
    set_box(0, 10, 20, 200, 300);
    set_box(1, 100, 900, 300, 1230);
    num_hazards = 4'd2;
    step("two_boxes", 32'h0000_E3E3);
    check("two_boxes.model", model_map(), 32'h0000_E3E3);

    num_hazards = 4'd1;
    step("gate_nh1", 32'h0000_0303);
    num_hazards = 4'd0;
    step("gate_nh0", 32'h0);

    set_box(0, 0, 0, 719, 1279);
    num_hazards = 4'd1;
    step("full_frame", 32'hFFFF_FFFF);

    set_box(0, 540, 159, 540, 160);
    step("boundary", 32'h0300_0000);

    set_box(0, 300, 500, 200, 600);
    step("degenerate", 32'h0);

    set_box(0, 720, 1280, 2000, 2047);
    step("off_frame", 32'h0);

    set_box(0, 700, 1200, 900, 1500);
    step("partial", 32'h8000_0000);

    // Reset mid-stream wins over the new map.
    set_box(0, 0, 0, 719, 1279);
    rst_n = 1'b0;
    step("mid_reset", 32'h0);
    rst_n = 1'b1;

    for (int k = 0; k < 20; k++) begin
      randomize_boxes();
      num_hazards = 4'($urandom_range(0, 15));
      exp_map = model_map();
      step($sformatf("latency%0d", k), exp_map);
    end

    for (int k = 0; k < 60; k++) begin
      randomize_boxes();
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(0, 3) == 0) set_box(i, $urandom_range(0, 719), $urandom_range(0, 1279),
                                               $urandom_range(0, 719), $urandom_range(0, 1279));
      end
      num_hazards = 4'($urandom_range(0, 15));
      exp_map = model_map();
      step($sformatf("rand%0d", k), exp_map);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
